// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump reader: sizes, FSM encoding,
// output beat layout and the register file's reset image.
package regfile_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 8;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_SEND  = 3'd2;
    localparam logic [STATE_W-1:0] ST_FIN   = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHK   = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] index;
        logic              last;
    } beat_t;

    // Register 0 in the low byte; register 4 comes out of reset holding 45.
    localparam logic [NUM_REGS*DATA_W-1:0] RESET_IMAGE =
        {8'd0, 8'd0, 8'd0, 8'd45, 8'd0, 8'd0, 8'd0, 8'd0};

    function automatic logic [DATA_W-1:0] resetValue(input logic [ADDR_W-1:0] idx);
        return RESET_IMAGE[int'(idx)*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/regdump_range_ctr.sv
// Walk pointer for the dump: loads the start index, steps with natural
// power-of-two wrap, and flags when it sits on the latched last index.
module regdump_range_ctr
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] firstReg,
    input  logic [ADDR_W-1:0] lastReg,
    output logic [ADDR_W-1:0] ptr,
    output logic              isLast
);

    logic [ADDR_W-1:0] lastIdx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            lastIdx <= '0;
        end else if (load) begin
            ptr     <= firstReg;
            lastIdx <= lastReg;
        end else if (advance) begin
            ptr <= ptr + 1'b1;
        end
    end

    assign isLast = (ptr == lastIdx);

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams a wrapping range of register-file entries out over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat to every dump.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  first_reg,
    input  logic [ADDR_W-1:0]  last_reg,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [ADDR_W-1:0]  out_index,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] dbgState
);

    // Handshake: a beat transfers on a posedge where out_valid && out_ready.
    // Once out_valid is high, the beat fields stay frozen until that transfer.
    logic [STATE_W-1:0] state;
    beat_t              beat;
    logic [ADDR_W-1:0]  ptr;
    logic               isLast;
    logic               load;
    logic               advance;
    logic               accept;

    assign accept  = out_valid && out_ready;
    assign load    = (state == ST_IDLE) && start;
    assign advance = (state == ST_SEND) && accept && !isLast;

    regdump_range_ctr u_rangeCtr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .advance  (advance),
        .firstReg (first_reg),
        .lastReg  (last_reg),
        .ptr      (ptr),
        .isLast   (isLast)
    );

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (load) begin
            checksum <= '0;
        end else if (state == ST_FETCH) begin
            checksum <= checksum ^ rd_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beat      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    beat.data  <= rd_data;
                    beat.index <= ptr;
`ifdef REGDUMP_CHECKSUM_EN
                    beat.last  <= 1'b0;
`else
                    beat.last  <= isLast;
`endif
                    out_valid  <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (!isLast) begin
                            state <= ST_FETCH;
                        end else begin
`ifdef REGDUMP_CHECKSUM_EN
                            // checksum already folds in the beat just accepted
                            beat      <= '{data: checksum, index: '0, last: 1'b1};
                            out_valid <= 1'b1;
                            state     <= ST_CHK;
`else
                            state <= ST_FIN;
`endif
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        state     <= ST_FIN;
                    end
                end
`endif
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_addr   = ptr;
    assign out_data  = beat.data;
    assign out_index = beat.index;
    assign out_last  = beat.last;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FIN);
    assign dbgState  = state;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized scoreboard bench for regfile_dump_reader, with a register file
// model on the read port and a reference model of the dump sequence.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    localparam int EW = DATA_W + ADDR_W + 1;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [ADDR_W-1:0]  first_reg;
    logic [ADDR_W-1:0]  last_reg;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [ADDR_W-1:0]  out_index;
    logic               out_last;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] dbgState;

    logic [DATA_W-1:0] regs [NUM_REGS];
    assign rd_data = regs[rd_addr];

    regfile_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .dbgState  (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    int readyPct = 100;
    bit pendingDone = 0;
    bit prevHeld = 0;
    logic [EW-1:0] prevBeat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic loadResetImage();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = resetValue(ADDR_W'(i));
    endtask

    // ready driver: changes just after each posedge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) < readyPct);
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        act = {out_data, out_index, out_last};
        if (!rst_n) begin
            prevHeld    = 0;
            pendingDone = 0;
        end else begin
            check("done", done, pendingDone);
            pendingDone = 0;
            if (prevHeld) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", act, prevBeat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", act);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", act, exp);
                    if (exp[0]) pendingDone = 1;
                end
                prevHeld = 0;
            end else begin
                prevHeld = out_valid;
                prevBeat = act;
            end
        end
    end

    // driver: one dump request, with optional mid-dump register write and a
    // start pulse issued while busy that must be ignored
    task automatic doDump(input int f, input int l, input bit wrEn, input int wrIdx,
                          input logic [DATA_W-1:0] wrVal, input bit ghost);
        logic [DATA_W-1:0] snap [NUM_REGS];
        logic [DATA_W-1:0] x;
        int n;
        int cnt;
        int idx;
        @(posedge clk);
        #2;
        cnt = 0;
        while (busy && cnt < 500) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        snap = regs;
        if (wrEn) snap[wrIdx] = wrVal;
        n = ((l - f + NUM_REGS) % NUM_REGS) + 1;
        x = '0;
        for (int i = 0; i < n; i++) begin
            idx = (f + i) % NUM_REGS;
            x ^= snap[idx];
`ifdef REGDUMP_CHECKSUM_EN
            exp_q.push_back({snap[idx], ADDR_W'(idx), 1'b0});
`else
            exp_q.push_back({snap[idx], ADDR_W'(idx), (i == n - 1)});
`endif
        end
`ifdef REGDUMP_CHECKSUM_EN
        exp_q.push_back({x, ADDR_W'(0), 1'b1});
`endif
        if (wrEn) begin
            fork
                begin
                    int c;
                    c = 0;
                    while (c < 100) begin
                        @(negedge clk);
                        if (busy && !out_valid && rd_addr == ADDR_W'(wrIdx)) break;
                        c++;
                    end
                    if (c >= 100) begin
                        checks++;
                        failures++;
                        $display("FAIL write_window actual=timeout required=fetch_of_%0d", wrIdx);
                    end else begin
                        regs[wrIdx] = wrVal;
                    end
                end
            join_none
        end
        start     = 1'b1;
        first_reg = ADDR_W'(f);
        last_reg  = ADDR_W'(l);
        @(posedge clk);
        #2;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("latency_fetch", out_valid, 0);
        @(posedge clk);
        #2;
        check("latency_valid", out_valid, 1);
        if (ghost) begin
            start     = 1'b1;
            first_reg = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            last_reg  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        cnt = 0;
        while (busy && cnt < 2000) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        if (cnt >= 2000) begin
            checks++;
            failures++;
            $display("FAIL dump_timeout actual=busy required=idle");
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        start     = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        loadResetImage();
        #1;
        check("reset_state", dbgState, ST_IDLE);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_valid", out_valid, 0);
        check("reset_outputs", {out_data, out_index, out_last, busy, done}, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // full scan of the reset image
        doDump(0, 7, 0, 0, 0, 0);

        // backpressure on a single-beat dump
        readyPct = 0;
        fork
            doDump(4, 4, 0, 0, 0, 0);
            begin
                repeat (8) @(posedge clk);
                readyPct = 100;
            end
        join

        // wrapping range
        doDump(6, 1, 0, 0, 0, 0);

        // write into register 2 just before it is fetched, plus a start while busy
        doDump(0, 7, 1, 2, 8'h5A, 1);

        // reset while a beat for index 3 is waiting
        readyPct = 0;
        @(posedge clk);
        #2;
        start     = 1'b1;
        first_reg = 3'd3;
        last_reg  = 3'd5;
        @(posedge clk);
        #2;
        start = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        check("pre_reset_index", out_index, 3);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_done", done, 0);
        exp_q.delete();
        loadResetImage();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_done", done, 0);
        #2;
        rst_n = 1'b1;
        readyPct = 100;
        doDump(0, 0, 0, 0, 0, 0);

        // randomized dumps
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NUM_REGS; i++)
                if ($urandom_range(0, 1) == 1) regs[i] = DATA_W'($urandom);
            readyPct = $urandom_range(30, 100);
            doDump($urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1),
                   0, 0, 0, ($urandom_range(0, 3) == 0));
        end
        readyPct = 100;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
